// File: rtl/multiplicador_if.sv
// Operand/result bundle between the requester, the multiplier and the consumer.
// The requester and consumer both drive from the master side.
interface multiplicador_if #(
   parameter int N = 16
);
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           ready;
   logic           ack;
   logic [2*N-1:0] producto;
   logic           Done_Flag;

   modport master (
      output a, b, ready, ack,
      input  producto, Done_Flag
   );

   modport slave (
      input  a, b, ready, ack,
      output producto, Done_Flag
   );
endinterface

// File: rtl/multiplicador.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock.
// The result is held with Done_Flag until the consumer acknowledges it.
module multiplicador #(
   parameter int N = 16
) (
   input  logic            clk,
   input  logic            reset,
   multiplicador_if.slave  bus
);
   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_q, state_d;
   logic [2*N-1:0]   a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic [2*N-1:0]   acc_q, acc_d;
   logic [CW-1:0]    count_q, count_d;
   logic [2*N-1:0]   producto_q, producto_d;
   logic             done_q, done_d;
   logic [2*N-1:0]   sum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         count_q    <= '0;
         producto_q <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         count_q    <= count_d;
         producto_q <= producto_d;
         done_q     <= done_d;
      end
   end

   // Partial product for the current multiplier bit; cannot overflow 2N bits.
   assign sum = b_q[0] ? (acc_q + a_q) : acc_q;

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      count_d    = count_q;
      producto_d = producto_q;
      done_d     = done_q;

      unique case (state_q)
         IDLE: begin
            done_d = 1'b0;
            if (bus.ready) begin
               a_d     = {{N{1'b0}}, bus.a};
               b_d     = bus.b;
               acc_d   = '0;
               count_d = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d   = sum;
            a_d     = a_q << 1;
            b_d     = b_q >> 1;
            count_d = count_q + 1'b1;
            // Fixed N-edge latency: no early exit when the multiplier runs out of ones.
            if (count_q == CW'(N - 1)) begin
               producto_d = sum;
               done_d     = 1'b1;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (bus.ack) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.producto  = producto_q;
   assign bus.Done_Flag = done_q;
endmodule

// File: tb/tb_multiplicador.sv
// Directed bench for multiplicador: latency, hold, ack handshake, async abort, back-to-back.
module tb_multiplicador;
   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   multiplicador_if #(.N(16)) bus ();

   multiplicador #(.N(16)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Start an operation and step through the 16 CALC edges; optionally
   // scramble inputs during CALC to prove they are ignored.
   task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                         input logic [31:0] exp, input string tag, input bit disturb);
      @(negedge clk);
      bus.a = av; bus.b = bv; bus.ready = 1'b1; bus.ack = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.ready = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (disturb && i < 15) begin
            bus.a     = 16'($urandom);
            bus.b     = 16'($urandom);
            bus.ready = ~bus.ready;
            bus.ack   = ~bus.ack;
         end else begin
            bus.ready = 1'b0;
            bus.ack   = 1'b0;
         end
      end
      check({tag, " done_low_edge15"}, {31'b0, bus.Done_Flag}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check({tag, " done_edge16"}, {31'b0, bus.Done_Flag}, 32'd1);
      check({tag, " producto"}, bus.producto, exp);
      $display("[TB] op %s: a=%h b=%h producto=%h expected=%h", tag, av, bv, bus.producto, exp);
   endtask

   task automatic do_ack(input string tag);
      bus.ack = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.ack = 1'b0;
      check({tag, " done_after_ack"}, {31'b0, bus.Done_Flag}, 32'd0);
   endtask

   initial begin
      int n;
      tests = 0;
      fails = 0;
      bus.a = '0; bus.b = '0; bus.ready = 1'b0; bus.ack = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset producto", bus.producto, 32'd0);
      check("reset done", {31'b0, bus.Done_Flag}, 32'd0);
      rst_n = 1'b1;

      // 1: basic product and indefinite hold without ack
      run_op(16'd16, 16'd31, 32'h0000_01F0, "t1", 1'b0);
      repeat (22) @(negedge clk);
      check("t1 hold done", {31'b0, bus.Done_Flag}, 32'd1);
      check("t1 hold producto", bus.producto, 32'h0000_01F0);
      do_ack("t1");

      // 2: full-range operands, then stay idle without ready
      run_op(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "t2", 1'b0);
      do_ack("t2");
      repeat (4) @(negedge clk);
      check("t2 idle done", {31'b0, bus.Done_Flag}, 32'd0);
      check("t2 idle producto", bus.producto, 32'hFFFE_0001);

      // 3: zero operands keep the full latency
      run_op(16'h1234, 16'h0000, 32'd0, "t3a", 1'b0);
      do_ack("t3a");
      run_op(16'h0000, 16'hBEEF, 32'd0, "t3b", 1'b0);
      do_ack("t3b");

      // 4: inputs toggled during CALC
      run_op(16'd3, 16'd5, 32'd15, "t4", 1'b1);
      do_ack("t4");

      // 5: asynchronous abort in the middle of CALC
      @(negedge clk);
      bus.a = 16'h00FF; bus.b = 16'h0101; bus.ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.ready = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5 abort producto", bus.producto, 32'd0);
      check("t5 abort done", {31'b0, bus.Done_Flag}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("t5 no resume done", {31'b0, bus.Done_Flag}, 32'd0);
      run_op(16'h00FF, 16'h0101, 32'h0000_FFFF, "t5", 1'b0);
      do_ack("t5");

      // 6: ready held high; each op is start + 16 CALC edges, then the ack edge
      @(negedge clk);
      bus.a = 16'd7; bus.b = 16'd9; bus.ready = 1'b1;
      for (int op = 0; op < 3; op++) begin
         n = 0;
         do begin
            @(posedge clk);
            @(negedge clk);
            n++;
         end while (!bus.Done_Flag && n < 40);
         check("t6 edges to done", 32'(n), 32'd17);
         check("t6 producto", bus.producto, 32'd63);
         $display("[TB] op t6.%0d: a=0007 b=0009 producto=%h edges=%0d", op, bus.producto, n);
         do_ack("t6");
      end
      bus.ready = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
